// File: rtl/cpu_trace_checker.sv
// Compares a CPU register write-back stream against a preloaded list of expected
// {register, value} entries and reports PASS, FAIL (mismatch) or FAIL (timeout).
module cpu_trace_checker #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic        sysclk,
  input  logic        reset_n,
  input  logic        ld_en,
  input  logic [4:0]  ld_reg,
  input  logic [31:0] ld_data,
  input  logic        start,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        timeout,
  output logic [7:0]  fail_idx,
  output logic [7:0]  load_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  // load_cnt can reach DEPTH, which needs 9 bits at DEPTH=256; clamp to the 8-bit port
  function automatic logic [7:0] sat8(input logic [CW-1:0] v);
    if (v > CW'(255)) begin
      return 8'hFF;
    end else begin
      return 8'(v);
    end
  endfunction

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_idx;
  logic [TW-1:0]   r_to;
  logic            r_busy;
  logic            r_done;
  logic            r_error;
  logic            r_timeout;
  logic [AW-1:0]   r_fail_idx;
  logic [36:0]     r_mem [DEPTH];

  state_t          w_state_nxt;
  logic            w_ld_acc;
  logic [CW-1:0]   w_cnt_nxt;
  logic [CW-1:0]   w_idx_nxt;
  logic [TW-1:0]   w_to_nxt;
  logic            w_timeout_nxt;
  logic [AW-1:0]   w_fail_idx_nxt;
  logic [36:0]     w_entry;
  logic            w_match;
  logic            w_last;

  // Next-state and datapath decisions
  always_comb begin
    w_ld_acc       = (r_state == S_IDLE) && ld_en && (r_cnt != CNT_FULL);
    w_cnt_nxt      = w_ld_acc ? (r_cnt + CW'(1)) : r_cnt;
    w_entry        = r_mem[r_idx[AW-1:0]];
    w_match        = (w_entry == {wb_reg, wb_data});
    w_last         = (r_idx == (r_cnt - CW'(1)));
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_to_nxt       = r_to;
    w_timeout_nxt  = r_timeout;
    w_fail_idx_nxt = r_fail_idx;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_idx_nxt = '0;
          w_to_nxt  = '0;
          // a load on the start cycle is counted, so only a truly empty list passes at once
          if (w_cnt_nxt == '0) begin
            w_state_nxt = S_PASS;
          end else begin
            w_state_nxt = S_RUN;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (wb_valid) begin
          if (w_match) begin
            w_idx_nxt = r_idx + CW'(1);
            w_to_nxt  = '0;
            if (w_last) begin
              w_state_nxt = S_PASS;
            end else begin
              w_state_nxt = S_RUN;
            end
          end else begin
            w_state_nxt    = S_FAIL;
            w_timeout_nxt  = 1'b0;
            w_fail_idx_nxt = r_idx[AW-1:0];
          end
        end else if (r_to == TO_LAST) begin
          w_state_nxt    = S_FAIL;
          w_timeout_nxt  = 1'b1;
          w_fail_idx_nxt = r_idx[AW-1:0];
        end else begin
          w_to_nxt = r_to + TW'(1);
        end
      end
      S_PASS: begin
        w_state_nxt = S_PASS;
      end
      S_FAIL: begin
        w_state_nxt = S_FAIL;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters and registered status
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_to       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_timeout  <= 1'b0;
      r_fail_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_to       <= w_to_nxt;
      r_busy     <= (w_state_nxt == S_RUN);
      r_done     <= (w_state_nxt == S_PASS) || (w_state_nxt == S_FAIL);
      r_error    <= (w_state_nxt == S_FAIL);
      r_timeout  <= w_timeout_nxt;
      r_fail_idx <= w_fail_idx_nxt;
    end
  end

  // Expected-entry storage is not reset; load_cnt alone marks valid entries
  always_ff @(posedge sysclk) begin
    if (reset_n && w_ld_acc) begin
      r_mem[r_cnt[AW-1:0]] <= {ld_reg, ld_data};
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign timeout  = r_timeout;
  assign fail_idx = 8'(r_fail_idx);
  assign load_cnt = sat8(r_cnt);

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Directed bench for cpu_trace_checker: stimulus pushes expected verdicts into a
// scoreboard queue, and a monitor pops and checks one each time done rises.
module tb_cpu_trace_checker;

  logic        sysclk = 1'b0;
  logic        reset_n;
  logic        ld_en;
  logic [4:0]  ld_reg;
  logic [31:0] ld_data;
  logic        start;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        busy;
  logic        done;
  logic        error;
  logic        timeout;
  logic [7:0]  fail_idx;
  logic [7:0]  load_cnt;

  cpu_trace_checker #(.DEPTH(16), .TIMEOUT(64)) dut (
    .sysclk   (sysclk),
    .reset_n  (reset_n),
    .ld_en    (ld_en),
    .ld_reg   (ld_reg),
    .ld_data  (ld_data),
    .start    (start),
    .wb_valid (wb_valid),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .timeout  (timeout),
    .fail_idx (fail_idx),
    .load_cnt (load_cnt)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    string      name;
    int         bcyc;
    logic       err;
    logic       to;
    logic [7:0] fidx;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string n, input int b, input logic e, input logic t,
                          input logic [7:0] f, input logic [7:0] c);
    exp_t x;
    x.name = n; x.bcyc = b; x.err = e; x.to = t; x.fidx = f; x.cnt = c;
    sb.push_back(x);
  endtask

  // Monitor: counts busy cycles per run and checks the verdict when done rises
  int   bcnt = 0;
  logic prev_done = 1'b0;
  exp_t mon_e;
  always @(negedge sysclk) begin
    if (done === 1'b1 && prev_done !== 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_verdict: done rose with error=%0b but none expected", error);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_busy_cycles"}, bcnt, mon_e.bcyc);
        chk({mon_e.name, "_error"}, {31'd0, error}, {31'd0, mon_e.err});
        chk({mon_e.name, "_timeout"}, {31'd0, timeout}, {31'd0, mon_e.to});
        chk({mon_e.name, "_fail_idx"}, {24'd0, fail_idx}, {24'd0, mon_e.fidx});
        chk({mon_e.name, "_load_cnt"}, {24'd0, load_cnt}, {24'd0, mon_e.cnt});
      end
      bcnt = 0;
    end
    if (busy === 1'b1) bcnt++;
    else if (done !== 1'b1) bcnt = 0;
    prev_done = done;
  end

  task automatic rst();
    reset_n = 1'b0;
    @(negedge sysclk);
    reset_n = 1'b1;
  endtask

  task automatic load(input logic [4:0] r, input logic [31:0] d);
    ld_en = 1'b1; ld_reg = r; ld_data = d;
    @(negedge sysclk);
    ld_en = 1'b0; ld_reg = 5'd0; ld_data = 32'd0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_valid = 1'b1; wb_reg = r; wb_data = d;
    @(negedge sysclk);
    wb_valid = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge sysclk);
      k++;
    end
    if (done !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_wait: done=%0b after %0d cycles, required 1", name, done, budget);
    end
    @(negedge sysclk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},     {31'd0, busy},     32'd0);
    chk({tag, "_done"},     {31'd0, done},     32'd0);
    chk({tag, "_error"},    {31'd0, error},    32'd0);
    chk({tag, "_timeout"},  {31'd0, timeout},  32'd0);
    chk({tag, "_fail_idx"}, {24'd0, fail_idx}, 32'd0);
    chk({tag, "_load_cnt"}, {24'd0, load_cnt}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; ld_en = 1'b0; ld_reg = 5'd0; ld_data = 32'd0; start = 1'b0;
    wb_valid = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
    repeat (2) @(negedge sysclk);
    reset_n = 1'b1;
    chk_all_zero("reset");

    // Three matching write-backs, then terminal PASS ignores further activity
    load(5'd1, 32'h5); load(5'd2, 32'hA); load(5'd3, 32'hF);
    chk("t2_load_cnt", {24'd0, load_cnt}, 32'd3);
    push_exp("t2_pass", 3, 1'b0, 1'b0, 8'd0, 8'd3);
    pulse_start();
    wb(5'd1, 32'h5); wb(5'd2, 32'hA); wb(5'd3, 32'hF);
    wait_done("t2", 10);
    wb(5'd1, 32'h5);
    pulse_start();
    load(5'd9, 32'h9);
    chk("t2_term_done", {31'd0, done}, 32'd1);
    chk("t2_term_error", {31'd0, error}, 32'd0);
    chk("t2_term_busy", {31'd0, busy}, 32'd0);
    chk("t2_term_load_cnt", {24'd0, load_cnt}, 32'd3);

    // Data mismatch on the second write-back
    rst();
    load(5'd1, 32'h5); load(5'd2, 32'hA); load(5'd3, 32'hF);
    push_exp("t3_mismatch", 2, 1'b1, 1'b0, 8'd1, 8'd3);
    pulse_start();
    wb(5'd1, 32'h5); wb(5'd2, 32'hB);
    wait_done("t3", 10);

    // Timeout after 64 idle RUN cycles
    rst();
    load(5'd7, 32'h1234);
    push_exp("t4_timeout", 64, 1'b1, 1'b1, 8'd0, 8'd1);
    pulse_start();
    wait_done("t4", 100);

    // Match in the last allowed cycle wins over the timeout
    rst();
    load(5'd7, 32'h1234);
    push_exp("t5_late_match", 64, 1'b0, 1'b0, 8'd0, 8'd1);
    pulse_start();
    repeat (63) @(negedge sysclk);
    wb(5'd7, 32'h1234);
    wait_done("t5", 10);

    // Overfill: 20 loads into 16 entries, extras must not wrap
    rst();
    for (int i = 0; i < 20; i++) begin
      load(5'(i), (i < 16) ? (32'hA000 + 32'(i)) : (32'hB000 + 32'(i)));
    end
    chk("t6_load_cnt", {24'd0, load_cnt}, 32'd16);
    push_exp("t6_full", 16, 1'b0, 1'b0, 8'd0, 8'd16);
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      wb(5'(i), 32'hA000 + 32'(i));
    end
    wait_done("t6", 10);

    // Empty list passes one cycle after start
    rst();
    push_exp("t7_empty", 0, 1'b0, 1'b0, 8'd0, 8'd0);
    pulse_start();
    chk("t7_done_next", {31'd0, done}, 32'd1);
    chk("t7_error_next", {31'd0, error}, 32'd0);
    @(negedge sysclk);

    // Load and start in the same cycle: the new entry is checked too
    rst();
    load(5'd4, 32'h44);
    push_exp("t8_load_start", 2, 1'b0, 1'b0, 8'd0, 8'd2);
    ld_en = 1'b1; ld_reg = 5'd5; ld_data = 32'h55; start = 1'b1;
    @(negedge sysclk);
    ld_en = 1'b0; ld_reg = 5'd0; ld_data = 32'd0; start = 1'b0;
    wb(5'd4, 32'h44); wb(5'd5, 32'h55);
    wait_done("t8", 10);

    // Reset mid-RUN aborts silently, then a fresh run passes
    rst();
    load(5'd1, 32'h10); load(5'd2, 32'h20);
    pulse_start();
    wb(5'd1, 32'h10);
    rst();
    chk_all_zero("t9_after_reset");
    wb(5'd2, 32'h20);
    load(5'd1, 32'h10); load(5'd2, 32'h20);
    push_exp("t9_rerun", 2, 1'b0, 1'b0, 8'd0, 8'd2);
    pulse_start();
    wb(5'd1, 32'h10); wb(5'd2, 32'h20);
    wait_done("t9", 10);

    // Register 0 is compared, and a register-only mismatch fails
    rst();
    load(5'd0, 32'h55); load(5'd3, 32'h77);
    push_exp("t10_reg_mismatch", 2, 1'b1, 1'b0, 8'd1, 8'd2);
    pulse_start();
    wb(5'd0, 32'h55); wb(5'd4, 32'h77);
    wait_done("t10", 10);

    repeat (2) @(negedge sysclk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_trace_checker.md
CPU_TRACE_CHECKER -- requirements
Module: cpu_trace_checker

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, the number of expected write-back entries it can hold (power of 2, 2..256).
REQ-002 The block SHALL have parameter TIMEOUT, default 64, the maximum number of sysclk cycles allowed between accepted write-back events while running.
REQ-003 The block SHALL have port sysclk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit, the reset; synchronous and active-low.
REQ-005 The block SHALL have port ld_en, input, 1 bit, a load strobe that writes one expected entry.
REQ-006 The block SHALL have port ld_reg, input, 5 bits, the expected destination register of the entry being loaded.
REQ-007 The block SHALL have port ld_data, input, 32 bits, the expected write-back value of the entry being loaded.
REQ-008 The block SHALL have port start, input, 1 bit, a one-cycle pulse that begins checking.
REQ-009 The block SHALL have port wb_valid, input, 1 bit, which is high for one cycle per CPU register write-back.
REQ-010 The block SHALL have port wb_reg, input, 5 bits, the CPU destination register.
REQ-011 The block SHALL have port wb_data, input, 32 bits, the CPU write-back value.
REQ-012 The block SHALL have port busy, output, 1 bit, high while in the RUN state.
REQ-013 The block SHALL have port done, output, 1 bit, high in PASS and in FAIL (sticky).
REQ-014 The block SHALL have port error, output, 1 bit, high in FAIL (sticky).
REQ-015 The block SHALL have port timeout, output, 1 bit, high when FAIL was caused by the timeout.
REQ-016 The block SHALL have port fail_idx, output, 8 bits, the entry index at failure; zero-extended from log2(DEPTH) bits.
REQ-017 The block SHALL have port load_cnt, output, 8 bits, the number of entries currently loaded.

Function
REQ-018 The block SHALL implement the states IDLE, RUN, PASS and FAIL, encoded in a registered state machine.
REQ-019 In IDLE, ld_en=1 with load_cnt<DEPTH SHALL write {ld_reg, ld_data} at index load_cnt and increment load_cnt in the same edge.
REQ-020 In IDLE, ld_en=1 with load_cnt==DEPTH SHALL be ignored: no write, no wrap-around, no error.
REQ-021 ld_en outside IDLE SHALL be ignored.
REQ-022 In IDLE, start=1 SHALL move to RUN on the next edge; the read index and the timeout counter clear to 0 on that edge.
REQ-023 If ld_en and start are both high in IDLE, the load SHALL take effect and RUN SHALL include that entry.
REQ-024 start with load_cnt==0 SHALL go directly to PASS.
REQ-025 In RUN, when wb_valid=1, the check SHALL compare {wb_reg, wb_data} against the entry at the read index.
REQ-026 On a match, the read index SHALL increment and the timeout counter SHALL clear.
REQ-027 On a match of the last entry (index load_cnt-1), the next state SHALL be PASS.
REQ-028 On a mismatch, the next state SHALL be FAIL, with fail_idx set to the read index and timeout set to 0.
REQ-029 A write-back to wb_reg=0 SHALL still be compared; it is not filtered.
REQ-030 In RUN, when wb_valid=0, the timeout counter SHALL increment.
REQ-031 When the timeout counter reaches TIMEOUT-1 with wb_valid=0, the next state SHALL be FAIL, with timeout=1 and fail_idx set to the read index.
REQ-032 wb_valid=1 on the cycle the limit is reached SHALL take priority over the timeout.
REQ-033 Status SHALL be registered, so done and error assert one cycle after the deciding edge; checker latency from wb_valid to verdict is 1 cycle.
REQ-034 PASS and FAIL SHALL be terminal: start and wb_valid are ignored until reset.
REQ-035 wb_valid pulses seen in IDLE, PASS or FAIL SHALL be ignored.

Reset
REQ-036 reset_n=0 at a rising edge SHALL force IDLE and clear load_cnt, the read index, the timeout counter, busy, done, error, timeout and fail_idx to 0.
REQ-037 Reset asserted mid-RUN SHALL abort the check without asserting done.
REQ-038 Expected-entry storage need not be cleared by reset; only load_cnt invalidates it.

Verification
REQ-039 Load 3 entries {1,0x5},{2,0xA},{3,0xF}, pulse start, drive the 3 matching write-backs -> busy for 3 cycles, then done=1, error=0.
REQ-040 Same load, drive {2,0xB} as the 2nd write-back -> done=1, error=1, timeout=0, fail_idx=1.
REQ-041 Load 1 entry, start, hold wb_valid=0 -> FAIL after 64 cycles with timeout=1 and fail_idx=0; a match on cycle 63 instead yields PASS.
REQ-042 Issue 20 ld_en with DEPTH=16 -> load_cnt=16; the last 4 entries are ignored and the stored entries are unchanged.
REQ-043 Pulse start with load_cnt=0 -> done=1, error=0 one cycle later.
REQ-044 Assert reset_n=0 for 1 cycle during RUN, then reload and run a passing trace -> all outputs read 0 after reset, then PASS.
